// File: rtl/rotr_stages.sv
// -----------------------------------------------------------------------------
// rotr_stages
// Combinational logarithmic right rotator. Stage i rotates its input right by
// 2**i positions when amt[i] is set, otherwise it passes the word through.
// A chain of AMT_W stages therefore rotates right by any amount 0..WIDTH-1.
//
// Ports
//   a    in   WIDTH   data word to rotate
//   amt  in   AMT_W   unsigned rotate-right amount
//   y    out  WIDTH   a rotated right by amt
// -----------------------------------------------------------------------------
module rotr_stages #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] y
);

    // stage_s[0] is the input; stage_s[i+1] is the output of mux stage i.
    logic [WIDTH-1:0] stage_s [0:AMT_W];

    assign stage_s[0] = a;

    for (genvar i = 0; i < AMT_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        // Low SH bits wrap around to the top of the word on a right rotate.
        assign stage_s[i+1] = amt[i] ? {stage_s[i][SH-1:0], stage_s[i][WIDTH-1:SH]}
                                     : stage_s[i];
    end

    assign y = stage_s[AMT_W];

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// Registered 8-bit barrel rotator, left or right by 0..WIDTH-1 positions.
// A single right rotator does all the work: a left rotate is performed as
// reverse -> rotate right -> reverse, since rotl(a,k) == rev(rotr(rev(a),k)).
// The result appears on y one clock after the inputs are presented; a new
// input is accepted every cycle.
//
// Ports
//   clk    in   1       rising-edge clock
//   reset  in   1       synchronous active-high reset, clears y
//   a      in   WIDTH   data to rotate
//   amt    in   AMT_W   rotate amount 0..WIDTH-1
//   lr     in   1       0 = rotate left, 1 = rotate right
//   y      out  WIDTH   registered rotation result
// -----------------------------------------------------------------------------
module top #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             lr,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] a_rev_s;
    logic [WIDTH-1:0] rot_in_s;
    logic [WIDTH-1:0] rot_out_s;
    logic [WIDTH-1:0] rot_out_rev_s;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // Bit reversal at the input and at the rotator output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign a_rev_s[i]       = a[WIDTH-1-i];
        assign rot_out_rev_s[i] = rot_out_s[WIDTH-1-i];
    end

    // Left rotates take the reversed path on both sides of the rotator.
    assign rot_in_s = lr ? a : a_rev_s;

    rotr_stages #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_rotr (
        .a   (rot_in_s),
        .amt (amt),
        .y   (rot_out_s)
    );

    assign y_d = lr ? rot_out_s : rot_out_rev_s;

    // Output register; reset wins over new data.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Directed and exhaustive self-checking bench for the registered rotator.
// -----------------------------------------------------------------------------
module tb_top;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [2:0] amt;
    logic       lr;
    logic [7:0] y;

    int checks_cnt;
    int fail_cnt;

    top dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .amt   (amt),
        .lr    (lr),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: rotate via a doubled word.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int k, input logic dir);
        logic [15:0] dbl;
        logic [15:0] sh;
        dbl = {d, d};
        if (dir == 1'b0) begin
            sh = dbl << k;
            return sh[15:8];
        end else begin
            sh = dbl >> k;
            return sh[7:0];
        end
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    // Present one set of inputs, clock once, sample shortly after the edge.
    task automatic step(input logic r, input logic [7:0] d, input logic [2:0] k, input logic dir);
        reset = r;
        a     = d;
        amt   = k;
        lr    = dir;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tmp_y;

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        reset = 1'b1;
        a     = 8'h00;
        amt   = 3'd0;
        lr    = 1'b0;

        // 1. Reset with a=FF, then release.
        step(1'b1, 8'hFF, 3'd1, 1'b0);
        check_val("reset_ff", y, 8'h00);
        step(1'b1, 8'hFF, 3'd1, 1'b0);
        check_val("reset_hold", y, 8'h00);
        step(1'b0, 8'h93, 3'd1, 1'b0);
        check_val("post_reset", y, 8'h27);

        // 2. Left rotation.
        step(1'b0, 8'h93, 3'd3, 1'b0);
        check_val("rotl3", y, 8'h9C);
        step(1'b0, 8'h93, 3'd5, 1'b0);
        check_val("rotl5", y, 8'h72);

        // 3. Right rotation.
        step(1'b0, 8'h93, 3'd2, 1'b1);
        check_val("rotr2", y, 8'hE4);
        step(1'b0, 8'h93, 3'd4, 1'b1);
        check_val("rotr4", y, 8'h39);
        step(1'b0, 8'h93, 3'd6, 1'b1);
        check_val("rotr6", y, 8'h4E);

        // 4. Pass-through and max amount.
        step(1'b0, 8'h93, 3'd0, 1'b0);
        check_val("pass_l", y, 8'h93);
        step(1'b0, 8'h93, 3'd0, 1'b1);
        check_val("pass_r", y, 8'h93);
        step(1'b0, 8'h93, 3'd7, 1'b0);
        check_val("rotl7", y, 8'hC9);

        // 5. Back-to-back with a mid-stream reset.
        step(1'b0, 8'h01, 3'd1, 1'b0);
        check_val("b2b_0", y, 8'h02);
        step(1'b0, 8'h80, 3'd7, 1'b1);
        check_val("b2b_1", y, 8'h01);
        step(1'b0, 8'hA5, 3'd3, 1'b1);
        check_val("b2b_2", y, 8'hB4);
        step(1'b1, 8'h5A, 3'd2, 1'b0);
        check_val("b2b_rst", y, 8'h00);
        step(1'b0, 8'h5A, 3'd2, 1'b0);
        check_val("b2b_after", y, 8'h69);
        step(1'b0, 8'hF0, 3'd6, 1'b0);
        check_val("b2b_3", y, 8'h3C);

        // 6. Exhaustive against the reference model.
        for (int d = 0; d < 256; d++) begin
            for (int k = 0; k < 8; k++) begin
                for (int dir = 0; dir < 2; dir++) begin
                    step(1'b0, 8'(d), 3'(k), 1'(dir));
                    check_val("exh", y, ref_rot(8'(d), k, 1'(dir)));
                end
            end
        end

        // Identity rotl(a,k) == rotr(a,8-k) through the DUT on a few words.
        for (int d = 0; d < 256; d += 37) begin
            for (int k = 1; k < 8; k++) begin
                step(1'b0, 8'(d), 3'(k), 1'b0);
                tmp_y = y;
                step(1'b0, 8'(d), 3'(8 - k), 1'b1);
                check_val("ident", y, tmp_y);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
